alu_cc_stage: RTL and testbench
===============================

ALU_CC_STAGE -- requirements
Module: alu_cc_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 64, the operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  upstream operation present.
REQ-005 SHALL have port in_ready  output  1  stage can accept an operation this cycle.
REQ-006 SHALL have port alu_fun  input  2  operation: 0 add, 1 sub, 2 and, 3 xor.
REQ-007 SHALL have port a  input  WIDTH  operand A (valA), signed two's complement.
REQ-008 SHALL have port b  input  WIDTH  operand B (valB), signed two's complement.
REQ-009 SHALL have port set_cc  input  1  update condition codes with this operation's flags.
REQ-010 SHALL have port cond_fun  input  3  condition to evaluate for this operation.
REQ-011 SHALL have port out_valid  output  1  registered result present.
REQ-012 SHALL have port out_ready  input  1  downstream consumes result this cycle.
REQ-013 SHALL have port val_e  output  WIDTH  registered result.
REQ-014 SHALL have port cnd  output  1  registered condition outcome for this operation.
REQ-015 SHALL have ports cc_zf, cc_sf, cc_of  output  1 each  current condition-code register.

Function
REQ-016 SHALL accept an operation on a rising edge where in_valid=1 and in_ready=1 ("accept").
REQ-017 SHALL drive in_ready = !out_valid || out_ready (combinational, single output register).
REQ-018 SHALL register the result one cycle after accept: val_e, cnd, out_valid=1 visible the cycle after the accepting edge.
REQ-019 SHALL compute add as b + a, sub as b - a, and as b & a, xor as b ^ a, all modulo 2^WIDTH.
REQ-020 SHALL compute OF for add as (a[MSB]==b[MSB]) && (res[MSB]!=a[MSB]).
REQ-021 SHALL compute OF for sub as (a[MSB]!=b[MSB]) && (res[MSB]!=b[MSB]); OF SHALL be 0 for and/xor.
REQ-022 SHALL compute ZF = (res==0) and SF = res[MSB] for all operations.
REQ-023 SHALL load cc_zf/cc_sf/cc_of with the new flags on accept only when set_cc=1; otherwise CC holds.
REQ-024 SHALL evaluate cnd from the CC value held before the accepting edge (not this operation's flags): 0 always=1, 1 le=(SF^OF)|ZF, 2 l=SF^OF, 3 e=ZF, 4 ne=!ZF, 5 ge=!(SF^OF), 6 g=!(SF^OF)&!ZF, 7 reserved=0.
REQ-025 SHALL hold val_e, cnd, out_valid stable while out_valid=1 and out_ready=0 (stall); no accept, no CC update.
REQ-026 SHALL clear out_valid on an edge with out_valid=1, out_ready=1 and no accept.
REQ-027 SHALL, on an edge with out_valid=1, out_ready=1 and accept, replace val_e/cnd with the new result and keep out_valid=1 (back-to-back, full throughput).
REQ-028 SHALL ignore alu_fun, a, b, set_cc, cond_fun when no accept occurs.
REQ-029 SHALL treat each accept independently; two consecutive set_cc operations SHALL each see the CC left by the previous one in cnd.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously force out_valid=0, val_e=0, cnd=0, cc_zf=1, cc_sf=0, cc_of=0.
REQ-031 SHALL discard any pending result on reset assertion mid-operation; in_ready=1 from reset onward.
REQ-032 SHALL accept its first operation on the first rising edge after rst_n deasserts.

Verification
REQ-033 SHALL pass: add a=0x7FFF_FFFF_FFFF_FFFF, b=1, set_cc=1 -> next cycle val_e=0x8000_0000_0000_0000, cc_of=1, cc_sf=1, cc_zf=0.
REQ-034 SHALL pass: sub a=5, b=5, set_cc=1, then any op cond_fun=3 -> first val_e=0, cc_zf=1; second cnd=1.
REQ-035 SHALL pass: sub a=1, b=0x8000_0000_0000_0000, set_cc=1 -> val_e=0x7FFF_FFFF_FFFF_FFFF, cc_of=1, cc_sf=0; following cond_fun=2 (l) -> cnd=1.
REQ-036 SHALL pass: result valid with out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0, val_e unchanged, CC unchanged; out_ready=1 -> next op accepted same edge, out_valid stays 1.
REQ-037 SHALL pass: xor a=b=0xFF, set_cc=0 -> val_e=0, CC unchanged from prior value.
REQ-038 SHALL pass: rst_n pulsed low while out_valid=1, cc_zf=0 -> immediately out_valid=0, val_e=0, cc_zf=1, cc_sf=0, cc_of=0.

Source files
------------

// File: rtl/alu_cc_stage.sv
// alu_cc_stage: single-register ALU execute stage with a condition-code register and a
// valid/ready handshake. Rev 1.0
`default_nettype none

module alu_cc_stage #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_fun,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             set_cc,
  input  logic [2:0]       cond_fun,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] val_e,
  output logic             cnd,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of
);

  localparam int MSB = WIDTH - 1;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_XOR = 2'd3;

  localparam logic [2:0] C_ALWAYS = 3'd0;
  localparam logic [2:0] C_LE     = 3'd1;
  localparam logic [2:0] C_L      = 3'd2;
  localparam logic [2:0] C_E      = 3'd3;
  localparam logic [2:0] C_NE     = 3'd4;
  localparam logic [2:0] C_GE     = 3'd5;
  localparam logic [2:0] C_G      = 3'd6;

  logic             out_valid_q;
  logic [WIDTH-1:0] val_e_q;
  logic             cnd_q;
  logic             cc_zf_q, cc_sf_q, cc_of_q;

  logic [WIDTH-1:0] res_d;
  logic             of_d, zf_d, sf_d;
  logic             cnd_d;
  logic             lt;
  logic             accept;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    res_d = '0;
    of_d  = 1'b0;
    case (alu_fun)
      ALU_ADD: begin
        res_d = b + a;
        of_d  = (a[MSB] == b[MSB]) && (res_d[MSB] != a[MSB]);
      end
      ALU_SUB: begin
        res_d = b - a;
        of_d  = (a[MSB] != b[MSB]) && (res_d[MSB] != b[MSB]);
      end
      ALU_AND: res_d = b & a;
      ALU_XOR: res_d = b ^ a;
      default: res_d = '0;
    endcase
    zf_d = (res_d == '0);
    sf_d = res_d[MSB];
  end

  // Condition looks at the CC register as it stood before this operation.
  always_comb begin
    lt    = cc_sf_q ^ cc_of_q;
    cnd_d = 1'b0;
    case (cond_fun)
      C_ALWAYS: cnd_d = 1'b1;
      C_LE:     cnd_d = lt | cc_zf_q;
      C_L:      cnd_d = lt;
      C_E:      cnd_d = cc_zf_q;
      C_NE:     cnd_d = !cc_zf_q;
      C_GE:     cnd_d = !lt;
      C_G:      cnd_d = !lt && !cc_zf_q;
      default:  cnd_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      val_e_q     <= '0;
      cnd_q       <= 1'b0;
      cc_zf_q     <= 1'b1;
      cc_sf_q     <= 1'b0;
      cc_of_q     <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      val_e_q     <= res_d;
      cnd_q       <= cnd_d;
      if (set_cc) begin
        cc_zf_q <= zf_d;
        cc_sf_q <= sf_d;
        cc_of_q <= of_d;
      end
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign val_e     = val_e_q;
  assign cnd       = cnd_q;
  assign cc_zf     = cc_zf_q;
  assign cc_sf     = cc_sf_q;
  assign cc_of     = cc_of_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_cc_stage.sv
// tb_alu_cc_stage: table-driven vectors plus stall/reset sequences, scoreboard-checked.
`default_nettype none

module tb_alu_cc_stage;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   alu_fun;
  logic [W-1:0] a, b;
  logic         set_cc;
  logic [2:0]   cond_fun;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] val_e;
  logic         cnd;
  logic         cc_zf, cc_sf, cc_of;

  alu_cc_stage #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_fun(alu_fun), .a(a), .b(b), .set_cc(set_cc), .cond_fun(cond_fun),
    .out_valid(out_valid), .out_ready(out_ready), .val_e(val_e), .cnd(cnd),
    .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   fun;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         set;
    logic [2:0]   cond;
    logic [W-1:0] exp_val;
  } vec_t;

  typedef struct {
    logic [W-1:0] val;
    logic         cnd;
    logic [2:0]   cc;
  } exp_t;

  vec_t tbl[10];
  exp_t sb[$];
  logic [2:0] m_cc;  // {zf, sf, of}
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic cond_model(input logic [2:0] c, input logic [2:0] cc);
    logic zf, lt;
    zf = cc[2];
    lt = (cc[1] != cc[0]);
    case (c)
      3'd0: return 1'b1;
      3'd1: return lt || zf;
      3'd2: return lt;
      3'd3: return zf;
      3'd4: return !zf;
      3'd5: return !lt;
      3'd6: return !lt && !zf;
      default: return 1'b0;
    endcase
  endfunction

  // Drives an operation that the caller knows will be accepted on the next edge.
  task automatic drive_op(input logic [1:0] f, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic s, input logic [2:0] c);
    logic signed [W:0] sum;
    logic [W-1:0] r;
    logic of;
    exp_t e;
    in_valid = 1'b1; alu_fun = f; a = va; b = vb; set_cc = s; cond_fun = c;
    of = 1'b0;
    case (f)
      2'd0: begin sum = $signed({vb[W-1], vb}) + $signed({va[W-1], va}); r = sum[W-1:0]; of = sum[W] ^ sum[W-1]; end
      2'd1: begin sum = $signed({vb[W-1], vb}) - $signed({va[W-1], va}); r = sum[W-1:0]; of = sum[W] ^ sum[W-1]; end
      2'd2: r = vb & va;
      default: r = vb ^ va;
    endcase
    e.val = r;
    e.cnd = cond_model(c, m_cc);
    if (s) m_cc = {(r == '0), r[W-1], of};
    e.cc = m_cc;
    sb.push_back(e);
  endtask

  task automatic chk_out(input string tag);
    exp_t e;
    chk({tag, "_valid"}, out_valid, 1);
    if (sb.size() == 0) begin
      n_checks++;
      $display("FAIL %s_sb: got empty scoreboard expected pending entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_val"}, val_e, e.val);
      chk({tag, "_cnd"}, cnd, e.cnd);
      chk({tag, "_cc"}, {cc_zf, cc_sf, cc_of}, e.cc);
    end
  endtask

  initial begin
    tbl[0] = '{2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, 3'd0, 64'h8000_0000_0000_0000};
    tbl[1] = '{2'd1, 64'h5, 64'h5, 1'b1, 3'd2, 64'h0};
    tbl[2] = '{2'd2, 64'hF0, 64'h3C, 1'b0, 3'd3, 64'h30};
    tbl[3] = '{2'd1, 64'h1, 64'h8000_0000_0000_0000, 1'b1, 3'd4, 64'h7FFF_FFFF_FFFF_FFFF};
    tbl[4] = '{2'd3, 64'hFF, 64'hFF, 1'b0, 3'd2, 64'h0};
    tbl[5] = '{2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, 3'd5, 64'h0};
    tbl[6] = '{2'd1, 64'h3, 64'h2, 1'b1, 3'd6, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[7] = '{2'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 3'd1, 64'h0};
    tbl[8] = '{2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1'b1, 3'd7, 64'h1234};
    tbl[9] = '{2'd3, 64'hA5, 64'h5A, 1'b0, 3'd0, 64'hFF};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_fun = '0; a = '0; b = '0; set_cc = 1'b0; cond_fun = '0;
    m_cc = 3'b100;
    repeat (2) step();
    chk("rst_valid", out_valid, 0);
    chk("rst_val", val_e, 0);
    chk("rst_cnd", cnd, 0);
    chk("rst_cc", {cc_zf, cc_sf, cc_of}, 3'b100);
    chk("rst_ready", in_ready, 1);
    rst_n = 1'b1;

    // Back-to-back stream; the first vector is taken on the first edge after reset release.
    for (int i = 0; i < 10; i++) begin
      drive_op(tbl[i].fun, tbl[i].a, tbl[i].b, tbl[i].set, tbl[i].cond);
      step();
      chk_out($sformatf("v%0d", i));
      chk($sformatf("v%0d_tbl", i), val_e, tbl[i].exp_val);
      chk($sformatf("v%0d_rdy", i), in_ready, 1);
    end

    // Stall: result held for three cycles with an operation waiting upstream.
    drive_op(2'd0, 64'h2, 64'h1, 1'b1, 3'd0);
    step();
    chk_out("stlA");
    out_ready = 1'b0;
    in_valid = 1'b1; alu_fun = 2'd1; a = 64'h5; b = 64'h5; set_cc = 1'b1; cond_fun = 3'd4;
    #1;
    chk("stl_ready0", in_ready, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("stl%0d_valid", k), out_valid, 1);
      chk($sformatf("stl%0d_val", k), val_e, 64'h3);
      chk($sformatf("stl%0d_cc", k), {cc_zf, cc_sf, cc_of}, m_cc);
      chk($sformatf("stl%0d_rdy", k), in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("stl_ready1", in_ready, 1);
    drive_op(2'd1, 64'h5, 64'h5, 1'b1, 3'd4);
    step();
    chk_out("stlB");

    // Drain with garbage on the operand inputs: nothing may be accepted.
    in_valid = 1'b0; alu_fun = 2'd0; a = 64'($urandom); b = 64'($urandom); set_cc = 1'b1; cond_fun = 3'd0;
    step();
    chk("drain_valid", out_valid, 0);
    chk("drain_cc", {cc_zf, cc_sf, cc_of}, m_cc);
    step();
    chk("idle_val", val_e, 64'h0);
    chk("idle_cc", {cc_zf, cc_sf, cc_of}, m_cc);

    // Reset asserted while a result is pending.
    drive_op(2'd0, 64'h1, 64'h2, 1'b1, 3'd0);
    step();
    chk_out("preRst");
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_val", val_e, 0);
    chk("arst_cnd", cnd, 0);
    chk("arst_cc", {cc_zf, cc_sf, cc_of}, 3'b100);
    chk("arst_ready", in_ready, 1);
    m_cc = 3'b100;
    sb.delete();
    step();
    rst_n = 1'b1;
    drive_op(2'd1, 64'h1, 64'h8000_0000_0000_0000, 1'b1, 3'd2);
    step();
    chk_out("postRst");
    in_valid = 1'b0;
    step();
    chk("end_valid", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
